// File: rtl/mod_mult_solinas3_prod.sv
// Pipelined full-width unsigned multiplier (split-operand schoolbook) feeding the
// Solinas-3 reduction stage; valid flag and sideband travel with the data.
package mod_mult_solinas3_prod_pkg;

    function automatic int get_latency(input int in_pipe, input logic [2:0] lat_pipe_mh);
        return ((in_pipe != 0) ? 1 : 0) + int'(lat_pipe_mh[0]) + int'(lat_pipe_mh[1])
             + int'(lat_pipe_mh[2]);
    endfunction

endpackage

module mod_mult_solinas3_prod #(
    parameter int         MOD_W       = 64,
    parameter int         SIDE_W      = 8,
    parameter int         IN_PIPE     = 1,
    parameter logic [2:0] LAT_PIPE_MH = 3'b111
) (
    input  logic                                 clk,
    input  logic                                 s_rst,
    input  logic [MOD_W-1:0]                     a,
    input  logic [MOD_W-1:0]                     b,
    input  logic                                 in_avail,
    input  logic [(SIDE_W > 0 ? SIDE_W : 1)-1:0] in_side,
    output logic [2*MOD_W-1:0]                   z,
    output logic                                 out_avail,
    output logic [(SIDE_W > 0 ? SIDE_W : 1)-1:0] out_side
);

    localparam int H   = MOD_W / 2;
    localparam int P_W = 2 * H;
    localparam int M_W = P_W + 1;
    localparam int Z_W = 2 * MOD_W;
    localparam int SW  = (SIDE_W > 0) ? SIDE_W : 1;

    // bit k enables the register at the output of stage k (stage 0 = input capture)
    localparam logic [3:0] STAGE_EN = {LAT_PIPE_MH, (IN_PIPE != 0)};

    if ((MOD_W % 2) != 0 || MOD_W < 2) begin : g_bad_width
        $fatal(1, "mod_mult_solinas3_prod: MOD_W must be even and >= 2");
    end

    // ---------------- valid / sideband chain ----------------
    logic          vld_s  [0:4];
    logic [SW-1:0] side_s [0:4];

    assign vld_s[0]  = in_avail;
    assign side_s[0] = in_side;

    for (genvar k = 0; k < 4; k++) begin : g_ctl
        if (STAGE_EN[k]) begin : g_reg
            logic vld_q;

            always_ff @(posedge clk) begin
                if (s_rst) begin
                    vld_q <= 1'b0;
                end else begin
                    vld_q <= vld_s[k];
                end
            end

            assign vld_s[k+1] = vld_q;

            if (SIDE_W > 0) begin : g_side
                logic [SW-1:0] side_q;

                always_ff @(posedge clk) begin
                    if (s_rst) begin
                        side_q <= '0;
                    end else if (vld_s[k]) begin
                        side_q <= side_s[k];
                    end
                end

                assign side_s[k+1] = side_q;
            end else begin : g_noside
                assign side_s[k+1] = '0;
            end
        end else begin : g_thru
            assign vld_s[k+1]  = vld_s[k];
            assign side_s[k+1] = side_s[k];
        end
    end

    // ---------------- stage 0: operand capture ----------------
    logic [MOD_W-1:0] a_s0, b_s0;

    if (STAGE_EN[0]) begin : g_p0
        logic [MOD_W-1:0] a_q, b_q;

        always_ff @(posedge clk) begin
            if (s_rst) begin
                a_q <= '0;
                b_q <= '0;
            end else if (vld_s[0]) begin
                a_q <= a;
                b_q <= b;
            end
        end

        assign a_s0 = a_q;
        assign b_s0 = b_q;
    end else begin : g_p0_thru
        assign a_s0 = a;
        assign b_s0 = b;
    end

    // ---------------- stage 1: four half-width partial products ----------------
    logic [P_W-1:0] ll_d, lh_d, hl_d, hh_d;
    logic [P_W-1:0] ll_s1, lh_s1, hl_s1, hh_s1;

    assign ll_d = P_W'(a_s0[H-1:0])     * P_W'(b_s0[H-1:0]);
    assign lh_d = P_W'(a_s0[H-1:0])     * P_W'(b_s0[MOD_W-1:H]);
    assign hl_d = P_W'(a_s0[MOD_W-1:H]) * P_W'(b_s0[H-1:0]);
    assign hh_d = P_W'(a_s0[MOD_W-1:H]) * P_W'(b_s0[MOD_W-1:H]);

    if (STAGE_EN[1]) begin : g_p1
        logic [P_W-1:0] ll_q, lh_q, hl_q, hh_q;

        always_ff @(posedge clk) begin
            if (s_rst) begin
                ll_q <= '0;
                lh_q <= '0;
                hl_q <= '0;
                hh_q <= '0;
            end else if (vld_s[1]) begin
                ll_q <= ll_d;
                lh_q <= lh_d;
                hl_q <= hl_d;
                hh_q <= hh_d;
            end
        end

        assign ll_s1 = ll_q;
        assign lh_s1 = lh_q;
        assign hl_s1 = hl_q;
        assign hh_s1 = hh_q;
    end else begin : g_p1_thru
        assign ll_s1 = ll_d;
        assign lh_s1 = lh_d;
        assign hl_s1 = hl_d;
        assign hh_s1 = hh_d;
    end

    // ---------------- stage 2: middle sum, carry kept in bit P_W ----------------
    logic [M_W-1:0] mid_d;
    logic [M_W-1:0] mid_s2;
    logic [P_W-1:0] ll_s2, hh_s2;

    assign mid_d = M_W'(lh_s1) + M_W'(hl_s1);

    if (STAGE_EN[2]) begin : g_p2
        logic [M_W-1:0] mid_q;
        logic [P_W-1:0] ll_q, hh_q;

        always_ff @(posedge clk) begin
            if (s_rst) begin
                mid_q <= '0;
                ll_q  <= '0;
                hh_q  <= '0;
            end else if (vld_s[2]) begin
                mid_q <= mid_d;
                ll_q  <= ll_s1;
                hh_q  <= hh_s1;
            end
        end

        assign mid_s2 = mid_q;
        assign ll_s2  = ll_q;
        assign hh_s2  = hh_q;
    end else begin : g_p2_thru
        assign mid_s2 = mid_d;
        assign ll_s2  = ll_s1;
        assign hh_s2  = hh_s1;
    end

    // ---------------- stage 3: final recombination ----------------
    logic [Z_W-1:0] z_d;
    logic [Z_W-1:0] z_s3;

    assign z_d = (Z_W'(hh_s2) << P_W) + (Z_W'(mid_s2) << H) + Z_W'(ll_s2);

    if (STAGE_EN[3]) begin : g_p3
        logic [Z_W-1:0] z_q;

        always_ff @(posedge clk) begin
            if (s_rst) begin
                z_q <= '0;
            end else if (vld_s[3]) begin
                z_q <= z_d;
            end
        end

        assign z_s3 = z_q;
    end else begin : g_p3_thru
        assign z_s3 = z_d;
    end

    assign z         = z_s3;
    assign out_avail = vld_s[4];
    assign out_side  = (SIDE_W > 0) ? side_s[4] : '0;

endmodule

// File: tb/tb_mod_mult_solinas3_prod.sv
// Bench for mod_mult_solinas3_prod: directed vector table, hand-written
// multi-cycle sequences and a delay-line scoreboard over four configurations.
module tb_mod_mult_solinas3_prod;
    import mod_mult_solinas3_prod_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         s_rst;
    logic [63:0]  a, b;
    logic         in_avail;
    logic [7:0]   in_side;

    logic [127:0] z4, z2, zc;
    logic         ov4, ov2, ovc;
    logic [7:0]   os4, os2, osc;
    logic [63:0]  z32;
    logic         ov32;
    logic [0:0]   os32;

    mod_mult_solinas3_prod dut_main (
        .clk(clk), .s_rst(s_rst), .a(a), .b(b), .in_avail(in_avail), .in_side(in_side),
        .z(z4), .out_avail(ov4), .out_side(os4));

    mod_mult_solinas3_prod #(.IN_PIPE(0), .LAT_PIPE_MH(3'b101)) dut_lat2 (
        .clk(clk), .s_rst(s_rst), .a(a), .b(b), .in_avail(in_avail), .in_side(in_side),
        .z(z2), .out_avail(ov2), .out_side(os2));

    mod_mult_solinas3_prod #(.IN_PIPE(0), .LAT_PIPE_MH(3'b000)) dut_comb (
        .clk(clk), .s_rst(s_rst), .a(a), .b(b), .in_avail(in_avail), .in_side(in_side),
        .z(zc), .out_avail(ovc), .out_side(osc));

    mod_mult_solinas3_prod #(.MOD_W(32), .SIDE_W(0)) dut_m32 (
        .clk(clk), .s_rst(s_rst), .a(a[31:0]), .b(b[31:0]), .in_avail(in_avail), .in_side(1'b0),
        .z(z32), .out_avail(ov32), .out_side(os32));

    int pass_cnt = 0;
    int chk_cnt  = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%h required=%h", nm, act, exp);
    endtask

    function automatic logic [127:0] mul64(input logic [63:0] x, input logic [63:0] y);
        return {64'd0, x} * {64'd0, y};
    endfunction

    function automatic logic [63:0] mul32(input logic [31:0] x, input logic [31:0] y);
        return {32'd0, x} * {32'd0, y};
    endfunction

    // delay line of accepted inputs; taps at 2 and 4 model the two pipelined configs
    logic         dv [1:4];
    logic [63:0]  da [1:4];
    logic [63:0]  db [1:4];
    logic [7:0]   ds [1:4];
    logic [127:0] hz4, hz2;
    logic [7:0]   hs4, hs2;
    logic [63:0]  hz32;

    always @(posedge clk) begin
        if (s_rst) begin
            for (int k = 1; k <= 4; k++) dv[k] <= 1'b0;
            hz4 <= '0; hs4 <= '0; hz2 <= '0; hs2 <= '0; hz32 <= '0;
        end else begin
            for (int k = 2; k <= 4; k++) begin
                dv[k] <= dv[k-1]; da[k] <= da[k-1]; db[k] <= db[k-1]; ds[k] <= ds[k-1];
            end
            dv[1] <= in_avail; da[1] <= a; db[1] <= b; ds[1] <= in_side;
            if (dv[3]) begin
                hz4  <= mul64(da[3], db[3]);
                hs4  <= ds[3];
                hz32 <= mul32(da[3][31:0], db[3][31:0]);
            end
            if (dv[1]) begin
                hz2 <= mul64(da[1], db[1]);
                hs2 <= ds[1];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("sb_main", 160'({ov4, os4, z4}),  160'({dv[4], hs4, hz4}));
            chk("sb_lat2", 160'({ov2, os2, z2}),  160'({dv[2], hs2, hz2}));
            chk("sb_m32",  160'({ov32, os32, z32}), 160'({dv[4], 1'b0, hz32}));
            chk("sb_comb", 160'({ovc, osc, zc}),  160'({in_avail, in_side, mul64(a, b)}));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] ai, input logic [63:0] bi, input logic v,
                         input logic [7:0] s);
        a = ai; b = bi; in_avail = v; in_side = s;
    endtask

    function automatic logic [63:0] rand64();
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return 64'd1;
            2:       return '1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    typedef struct {
        logic [63:0]  a;
        logic [63:0]  b;
        logic [127:0] z;
    } vec_t;

    vec_t vecs [14];

    initial begin
        int lat4, lat2;
        logic [127:0] zcap;
        logic [6:0] bub;

        vecs[0]  = '{64'h0, 64'h0, 128'h0};
        vecs[1]  = '{64'h1, 64'h1, 128'h1};
        vecs[2]  = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 128'hFFFFFFFFFFFFFFFE0000000000000001};
        vecs[3]  = '{64'hFFFFFFFF00000000, 64'h00000000FFFFFFFF, 128'h00000000FFFFFFFE0000000100000000};
        vecs[4]  = '{64'hFFFFFFFFFFFFFFFF, 64'h1, 128'h0000000000000000FFFFFFFFFFFFFFFF};
        vecs[5]  = '{64'h8000000000000000, 64'h2, 128'h00000000000000010000000000000000};
        vecs[6]  = '{64'h8000000000000000, 64'h8000000000000000, 128'h40000000000000000000000000000000};
        vecs[7]  = '{64'h00000000FFFFFFFF, 64'h00000000FFFFFFFF, 128'h0000000000000000FFFFFFFE00000001};
        vecs[8]  = '{64'hFFFFFFFFFFFFFFFF, 64'h2, 128'h0000000000000001FFFFFFFFFFFFFFFE};
        vecs[9]  = '{64'h3, 64'h5, 128'hF};
        vecs[10] = '{64'h0000000100000000, 64'h0000000100000000, 128'h00000000000000010000000000000000};
        vecs[11] = '{64'h80000000, 64'h80000000, 128'h00000000000000004000000000000000};
        vecs[12] = '{64'h0, 64'hFFFFFFFFFFFFFFFF, 128'h0};
        vecs[13] = '{64'h12345678, 64'h10, 128'h00000000000000000000000123456780};

        s_rst = 1'b1;
        drive(64'd0, 64'd0, 1'b0, 8'd0);
        step();
        step();
        s_rst = 1'b0;
        chk_en = 1'b1;
        chk("reset_state", 160'({ov4, os4, z4}), 160'd0);

        // isolated items: latency and exact product
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].a, vecs[i].b, 1'b1, 8'(i + 8'h40));
            lat4 = -1; lat2 = -1; zcap = '0;
            for (int k = 1; k <= 6; k++) begin
                step();
                if (k == 1) drive(rand64(), rand64(), 1'b0, 8'($urandom));
                if (ov4 && lat4 < 0) begin lat4 = k; zcap = z4; end
                if (ov2 && lat2 < 0) lat2 = k;
            end
            chk($sformatf("lat_main[%0d]", i), 160'(lat4), 160'(get_latency(1, 3'b111)));
            chk($sformatf("lat_lat2[%0d]", i), 160'(lat2), 160'(get_latency(0, 3'b101)));
            chk($sformatf("z_vec[%0d]", i), 160'(zcap), 160'(vecs[i].z));
        end

        // narrow instance: 0x80000000 squared
        drive(64'h80000000, 64'h80000000, 1'b1, 8'd0);
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k == 1) drive(64'd7, 64'd9, 1'b0, 8'd0);
            if (k < 4) chk("m32_early", 160'(ov32), 160'(0));
        end
        chk("m32_z", 160'({ov32, z32}), 160'({1'b1, 64'h4000000000000000}));

        // 16 back-to-back items
        for (int i = 0; i < 20; i++) begin
            if (i < 16) drive(64'hFFFFFFFF00000000, 64'h00000000FFFFFFFF, 1'b1, 8'(i));
            else        drive(rand64(), rand64(), 1'b0, 8'hEE);
            step();
            if (i >= 3 && i < 19) chk($sformatf("b2b_side[%0d]", i - 3), 160'({ov4, os4}), 160'({1'b1, 8'(i - 3)}));
            if (i == 3) chk("b2b_z0", 160'(z4), 160'(128'h00000000FFFFFFFE0000000100000000));
            if (i == 19) chk("b2b_end", 160'(ov4), 160'(0));
        end

        // bubble pattern 1,0,1,1,0,0,1 (bit 0 first)
        bub = 7'b1001101;
        for (int i = 0; i < 12; i++) begin
            if (i < 7) drive(rand64(), rand64(), bub[i], 8'($urandom));
            else       drive(rand64(), rand64(), 1'b0, 8'($urandom));
            step();
            if (i >= 3 && i < 10) chk($sformatf("bubble[%0d]", i - 3), 160'(ov4), 160'(bub[i - 3]));
        end

        // reset while three items are in flight
        drive(64'hDEADBEEFCAFEF00D, 64'h0123456789ABCDEF, 1'b1, 8'hA1);
        step();
        drive(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b1, 8'hA2);
        step();
        drive(64'h5555555555555555, 64'hAAAAAAAAAAAAAAAA, 1'b1, 8'hA3);
        s_rst = 1'b1;
        step();
        s_rst = 1'b0;
        drive(64'd11, 64'd13, 1'b0, 8'hFF);
        for (int k = 1; k <= 6; k++) begin
            step();
            chk($sformatf("post_rst[%0d]", k), 160'({ov4, os4, z4}), 160'd0);
        end
        drive(64'd3, 64'd5, 1'b1, 8'h5A);
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k == 1) drive(64'd11, 64'd13, 1'b0, 8'hFF);
            if (k < 4) chk($sformatf("rst_new_early[%0d]", k), 160'(ov4), 160'(0));
        end
        chk("rst_new_item", 160'({ov4, os4, z4}), 160'({1'b1, 8'h5A, 128'd15}));

        // random traffic with occasional resets; the scoreboard does the checking
        for (int i = 0; i < 3000; i++) begin
            drive(rand64(), rand64(), 1'($urandom_range(0, 3) != 0), 8'($urandom));
            s_rst = ($urandom_range(0, 199) == 0);
            step();
        end
        s_rst = 1'b0;
        drive(64'd0, 64'd0, 1'b0, 8'd0);
        for (int k = 0; k < 6; k++) step();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
